// File: rtl/uart_giris_cikis_birimi_pkg.sv
// Shared definitions for the memory-mapped UART I/O responder: register
// offsets, status bit positions, FSM state types and the bit-period helper.
package uart_giris_cikis_birimi_pkg;

    // Upper address code of the I/O region served by this block.
    localparam logic [2:0] IO_BOLGE_KODU = 3'b010;

    // Word register offsets, decoded from address bits [3:2].
    localparam logic [1:0] REG_KONTROL = 2'd0;
    localparam logic [1:0] REG_DURUM   = 2'd1;
    localparam logic [1:0] REG_OKU     = 2'd2;
    localparam logic [1:0] REG_YAZ     = 2'd3;

    // Bit positions inside the DURUM register.
    localparam int DURUM_TX_BOS  = 0;
    localparam int DURUM_TX_DOLU = 1;
    localparam int DURUM_RX_BOS  = 2;
    localparam int DURUM_RX_DOLU = 3;

    typedef enum logic {
        BOSTA,
        YANIT
    } bus_durum_e;

    typedef enum logic [1:0] {
        TX_BOS,
        TX_BASLA,
        TX_VERI,
        TX_DUR
    } tx_durum_e;

    typedef enum logic [1:0] {
        RX_BOS,
        RX_BASLA,
        RX_VERI,
        RX_DUR
    } rx_durum_e;

    // A divisor below 2 would make a mid-bit sample point impossible.
    function automatic logic [15:0] bit_suresi(input logic [15:0] bol);
        return (bol < 16'd2) ? 16'd2 : bol;
    endfunction

endpackage

// File: rtl/uart_giris_cikis_birimi_if.sv
// Core-side load/store bus of the I/O responder. Signal suffixes are seen
// from the responder (slave) side.
interface uart_giris_cikis_birimi_if;
    import uart_giris_cikis_birimi_pkg::*;

    logic        giris_cikis_aktif_i;
    logic        bellege_yaz_i;
    logic [31:0] bellek_adresi_i;
    logic [31:0] yazilacak_veri_i;
    logic [31:0] okunan_veri_o;
    logic        veri_gecerli_o;
    logic        durdur_o;

    modport slave (
        input  giris_cikis_aktif_i,
        input  bellege_yaz_i,
        input  bellek_adresi_i,
        input  yazilacak_veri_i,
        output okunan_veri_o,
        output veri_gecerli_o,
        output durdur_o
    );

    modport master (
        output giris_cikis_aktif_i,
        output bellege_yaz_i,
        output bellek_adresi_i,
        output yazilacak_veri_i,
        input  okunan_veri_o,
        input  veri_gecerli_o,
        input  durdur_o
    );
endinterface

// File: rtl/uart_giris_cikis_birimi_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only when a pop happens in the same cycle, so the count stays unchanged.
module es_zamanli_fifo
    import uart_giris_cikis_birimi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             yaz;
    logic             oku;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign oku     = pop_i & ~empty_o;
    assign yaz     = push_i & (~full_o | oku);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (yaz) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    // Read/write pointers with one extra wrap bit for full/empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (yaz) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (oku) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_giris_cikis_birimi.sv
// Memory-mapped UART responder: bus FSM with one-cycle response, control
// register, 8N1 transmitter and receiver with TX/RX FIFOs.
module uart_giris_cikis_birimi
    import uart_giris_cikis_birimi_pkg::*;
#(
    parameter int          FIFO_DERINLIK  = 32,
    parameter logic [15:0] VARSAYILAN_BOL = 16'd868
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    uart_giris_cikis_birimi_if.slave  bus,
    output logic                      uart_tx_o,
    input  logic                      uart_rx_i
);
    // Control register
    logic [15:0] baud_bol_q;
    logic        rx_en_q;
    logic        tx_en_q;
    logic        ctrl_yaz;

    // Bus side
    bus_durum_e  bus_durum_q, bus_durum_d;
    logic [31:0] okunan_veri_q, okunan_veri_d;
    logic        tx_push_bus;
    logic        rx_pop_bus;
    logic [31:0] durum_kelime;

    // FIFO status/data
    logic [7:0]  tx_dout, rx_dout;
    logic        tx_dolu, tx_bos, rx_dolu, rx_bos;

    // Transmitter
    tx_durum_e   tx_durum_q, tx_durum_d;
    logic [15:0] tx_sayac_q, tx_sayac_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_kaydirma_q, tx_kaydirma_d;
    logic        tx_hat_q, tx_hat_d;
    logic        tx_pop;

    // Receiver
    logic        rx_s1_q, rx_s2_q, rx_onceki_q;
    rx_durum_e   rx_durum_q, rx_durum_d;
    logic [15:0] rx_sayac_q, rx_sayac_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_kaydirma_q, rx_kaydirma_d;
    logic        rx_push;

    // Bit timing, re-read at every bit start so divisor changes land cleanly.
    logic [15:0] tam_sure;
    logic [15:0] yarim_sure;
    assign tam_sure   = bit_suresi(baud_bol_q) - 16'd1;
    assign yarim_sure = (bit_suresi(baud_bol_q) >> 1) - 16'd1;

    es_zamanli_fifo #(.WIDTH(8), .DEPTH(FIFO_DERINLIK)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push_bus),
        .din_i   (bus.yazilacak_veri_i[7:0]),
        .pop_i   (tx_pop),
        .dout_o  (tx_dout),
        .full_o  (tx_dolu),
        .empty_o (tx_bos)
    );

    es_zamanli_fifo #(.WIDTH(8), .DEPTH(FIFO_DERINLIK)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .din_i   (rx_kaydirma_q),
        .pop_i   (rx_pop_bus),
        .dout_o  (rx_dout),
        .full_o  (rx_dolu),
        .empty_o (rx_bos)
    );

    // Status word assembly.
    always_comb begin
        durum_kelime                = '0;
        durum_kelime[DURUM_TX_BOS]  = tx_bos;
        durum_kelime[DURUM_TX_DOLU] = tx_dolu;
        durum_kelime[DURUM_RX_BOS]  = rx_bos;
        durum_kelime[DURUM_RX_DOLU] = rx_dolu;
    end

    assign bus.okunan_veri_o  = okunan_veri_q;
    assign bus.veri_gecerli_o = (bus_durum_q == YANIT);
    assign bus.durdur_o       = bus.giris_cikis_aktif_i & ~bus.veri_gecerli_o;
    assign uart_tx_o          = tx_hat_q;

    // Bus FSM state and response data registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bus_durum_q   <= BOSTA;
            okunan_veri_q <= '0;
        end else begin
            bus_durum_q   <= bus_durum_d;
            okunan_veri_q <= okunan_veri_d;
        end
    end

    // Request decode: side effects fire only on the accepting BOSTA cycle.
    always_comb begin
        bus_durum_d   = bus_durum_q;
        okunan_veri_d = okunan_veri_q;
        ctrl_yaz      = 1'b0;
        tx_push_bus   = 1'b0;
        rx_pop_bus    = 1'b0;
        case (bus_durum_q)
            BOSTA: begin
                if (bus.giris_cikis_aktif_i) begin
                    bus_durum_d   = YANIT;
                    okunan_veri_d = '0;
                    case (bus.bellek_adresi_i[3:2])
                        REG_KONTROL: begin
                            if (bus.bellege_yaz_i) ctrl_yaz = 1'b1;
                            else okunan_veri_d = {baud_bol_q, 14'b0, rx_en_q, tx_en_q};
                        end
                        REG_DURUM: begin
                            if (!bus.bellege_yaz_i) okunan_veri_d = durum_kelime;
                        end
                        REG_OKU: begin
                            if (!bus.bellege_yaz_i && !rx_bos) begin
                                rx_pop_bus    = 1'b1;
                                okunan_veri_d = {24'b0, rx_dout};
                            end
                        end
                        REG_YAZ: begin
                            if (bus.bellege_yaz_i) tx_push_bus = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            YANIT:   bus_durum_d = BOSTA;
            default: bus_durum_d = BOSTA;
        endcase
    end

    // Control register: divisor and enables.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            baud_bol_q <= VARSAYILAN_BOL;
            rx_en_q    <= 1'b0;
            tx_en_q    <= 1'b0;
        end else if (ctrl_yaz) begin
            baud_bol_q <= bus.yazilacak_veri_i[31:16];
            rx_en_q    <= bus.yazilacak_veri_i[1];
            tx_en_q    <= bus.yazilacak_veri_i[0];
        end
    end

    // Transmitter state registers; the line idles high.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tx_durum_q    <= TX_BOS;
            tx_sayac_q    <= '0;
            tx_bit_q      <= '0;
            tx_kaydirma_q <= '0;
            tx_hat_q      <= 1'b1;
        end else begin
            tx_durum_q    <= tx_durum_d;
            tx_sayac_q    <= tx_sayac_d;
            tx_bit_q      <= tx_bit_d;
            tx_kaydirma_q <= tx_kaydirma_d;
            tx_hat_q      <= tx_hat_d;
        end
    end

    // Transmitter sequencing: start, 8 data bits LSB first, stop.
    always_comb begin
        tx_durum_d    = tx_durum_q;
        tx_sayac_d    = tx_sayac_q;
        tx_bit_d      = tx_bit_q;
        tx_kaydirma_d = tx_kaydirma_q;
        tx_hat_d      = tx_hat_q;
        tx_pop        = 1'b0;
        case (tx_durum_q)
            TX_BOS: begin
                tx_hat_d = 1'b1;
                if (tx_en_q && !tx_bos) begin
                    tx_pop        = 1'b1;
                    tx_kaydirma_d = tx_dout;
                    tx_hat_d      = 1'b0;
                    tx_sayac_d    = tam_sure;
                    tx_durum_d    = TX_BASLA;
                end
            end
            TX_BASLA: begin
                if (tx_sayac_q == 16'd0) begin
                    tx_hat_d      = tx_kaydirma_q[0];
                    tx_kaydirma_d = tx_kaydirma_q >> 1;
                    tx_bit_d      = 3'd0;
                    tx_sayac_d    = tam_sure;
                    tx_durum_d    = TX_VERI;
                end else begin
                    tx_sayac_d = tx_sayac_q - 16'd1;
                end
            end
            TX_VERI: begin
                if (tx_sayac_q == 16'd0) begin
                    tx_sayac_d = tam_sure;
                    if (tx_bit_q == 3'd7) begin
                        tx_hat_d   = 1'b1;
                        tx_durum_d = TX_DUR;
                    end else begin
                        tx_hat_d      = tx_kaydirma_q[0];
                        tx_kaydirma_d = tx_kaydirma_q >> 1;
                        tx_bit_d      = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_sayac_d = tx_sayac_q - 16'd1;
                end
            end
            TX_DUR: begin
                if (tx_sayac_q == 16'd0) tx_durum_d = TX_BOS;
                else tx_sayac_d = tx_sayac_q - 16'd1;
            end
            default: tx_durum_d = TX_BOS;
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial input, plus edge history.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_onceki_q <= 1'b1;
        end else begin
            rx_s1_q     <= uart_rx_i;
            rx_s2_q     <= rx_s1_q;
            rx_onceki_q <= rx_s2_q;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rx_durum_q    <= RX_BOS;
            rx_sayac_q    <= '0;
            rx_bit_q      <= '0;
            rx_kaydirma_q <= '0;
        end else begin
            rx_durum_q    <= rx_durum_d;
            rx_sayac_q    <= rx_sayac_d;
            rx_bit_q      <= rx_bit_d;
            rx_kaydirma_q <= rx_kaydirma_d;
        end
    end

    // Receiver sequencing: start validation at half period, then mid-bit samples.
    always_comb begin
        rx_durum_d    = rx_durum_q;
        rx_sayac_d    = rx_sayac_q;
        rx_bit_d      = rx_bit_q;
        rx_kaydirma_d = rx_kaydirma_q;
        rx_push       = 1'b0;
        case (rx_durum_q)
            RX_BOS: begin
                if (rx_en_q && rx_onceki_q && !rx_s2_q) begin
                    rx_durum_d = RX_BASLA;
                    rx_sayac_d = yarim_sure;
                end
            end
            RX_BASLA: begin
                if (rx_sayac_q == 16'd0) begin
                    if (rx_s2_q) begin
                        rx_durum_d = RX_BOS;
                    end else begin
                        rx_durum_d = RX_VERI;
                        rx_sayac_d = tam_sure;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_sayac_d = rx_sayac_q - 16'd1;
                end
            end
            RX_VERI: begin
                if (rx_sayac_q == 16'd0) begin
                    rx_kaydirma_d = {rx_s2_q, rx_kaydirma_q[7:1]};
                    rx_sayac_d    = tam_sure;
                    if (rx_bit_q == 3'd7) rx_durum_d = RX_DUR;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end else begin
                    rx_sayac_d = rx_sayac_q - 16'd1;
                end
            end
            RX_DUR: begin
                if (rx_sayac_q == 16'd0) begin
                    rx_push    = rx_s2_q;
                    rx_durum_d = RX_BOS;
                end else begin
                    rx_sayac_d = rx_sayac_q - 16'd1;
                end
            end
            default: rx_durum_d = RX_BOS;
        endcase
    end
endmodule

// File: tb/tb_uart_giris_cikis_birimi.sv
// Self-checking bench for the UART I/O responder: queue-based FIFO model,
// serial frame decoder on uart_tx_o and a serial frame generator on uart_rx_i.
module tb_uart_giris_cikis_birimi;
    import uart_giris_cikis_birimi_pkg::*;

    localparam int DER = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic uart_tx;
    logic uart_rx;

    int n_kontrol = 0;
    int n_hata    = 0;

    logic [7:0] rx_model[$];
    logic [7:0] tx_model[$];
    logic [7:0] tx_alinan[$];
    int         mon_per = 4;
    bit         mon_en  = 1'b1;

    uart_giris_cikis_birimi_if bus_if ();

    uart_giris_cikis_birimi #(.FIFO_DERINLIK(DER), .VARSAYILAN_BOL(16'd868)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .bus       (bus_if.slave),
        .uart_tx_o (uart_tx),
        .uart_rx_i (uart_rx)
    );

    always #5 clk = ~clk;

    initial begin : bekcik
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] adr(input logic [1:0] ofs);
        return {1'b0, IO_BOLGE_KODU, 22'h0, 2'b00, ofs, 2'b00};
    endfunction

    // Expected status word from the number of bytes held in each FIFO.
    function automatic logic [31:0] durum_bekle(input int rx_n, input int tx_n);
        return {28'h0, rx_n == DER, rx_n == 0, tx_n == DER, tx_n == 0};
    endfunction

    task automatic bekle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_islem(input logic yaz, input logic [1:0] ofs, input logic [31:0] veri,
                             output logic [31:0] okunan, output int gecikme);
        @(posedge clk); #1;
        bus_if.giris_cikis_aktif_i = 1'b1;
        bus_if.bellege_yaz_i       = yaz;
        bus_if.bellek_adresi_i     = adr(ofs);
        bus_if.yazilacak_veri_i    = veri;
        gecikme = 0;
        okunan  = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus_if.veri_gecerli_o === 1'b1) begin
                gecikme = i;
                okunan  = bus_if.okunan_veri_o;
                break;
            end
        end
        bus_if.giris_cikis_aktif_i = 1'b0;
        n_kontrol++;
        if (gecikme == 0) begin
            n_hata++;
            $display("FAIL bus_timeout: got no response required response within 8 cycles");
        end
        $display("bus %s reg=%0d wdata=%08h rdata=%08h latency=%0d", yaz ? "ST" : "LD", ofs, veri, okunan, gecikme);
    endtask

    // Serial frame generator: start, 8 bits LSB first, given stop level, idle.
    task automatic rx_gonder(input logic [7:0] b, input logic stop, input int per);
        uart_rx = 1'b0;
        bekle(per);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            bekle(per);
        end
        uart_rx = stop;
        bekle(per);
        uart_rx = 1'b1;
        bekle(per);
        $display("rx frame byte=%02h stop=%0b period=%0d", b, stop, per);
    endtask

    // Frame decoder for uart_tx_o, sampling each bit mid-period.
    initial begin : tx_monitor
        logic [7:0] mb;
        logic       ms;
        forever begin
            @(posedge clk); #1;
            if (mon_en && rst_n === 1'b1 && uart_tx === 1'b0) begin
                repeat (mon_per / 2) @(posedge clk);
                #1;
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (mon_per) @(posedge clk);
                        #1;
                        mb[i] = uart_tx;
                    end
                    repeat (mon_per) @(posedge clk);
                    #1;
                    ms = uart_tx;
                    if (mon_en) begin
                        n_kontrol++;
                        if (ms !== 1'b1) begin
                            n_hata++;
                            $display("FAIL tx_stop_bit: got %0b required 1", ms);
                        end
                        tx_alinan.push_back(mb);
                        $display("tx frame decoded byte=%02h", mb);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [31:0] r;
        int g;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        bus_if.giris_cikis_aktif_i = 1'b0;
        bus_if.bellege_yaz_i = 1'b0;
        bus_if.bellek_adresi_i = '0;
        bus_if.yazilacak_veri_i = '0;
        bekle(4);
        n_kontrol++;
        if (uart_tx !== 1'b1) begin n_hata++; $display("FAIL reset_tx_line: got %b required 1", uart_tx); end
        n_kontrol++;
        if (bus_if.veri_gecerli_o !== 1'b0) begin n_hata++; $display("FAIL reset_valid: got %b required 0", bus_if.veri_gecerli_o); end
        n_kontrol++;
        if (bus_if.okunan_veri_o !== 32'h0) begin n_hata++; $display("FAIL reset_rdata: got %08h required 0", bus_if.okunan_veri_o); end
        rst_n = 1'b1;
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (g != 1) begin n_hata++; $display("FAIL reset_latency: got %0d required 1", g); end
        n_kontrol++;
        if (r !== 32'h5) begin n_hata++; $display("FAIL reset_durum: got %08h required 00000005", r); end
        bus_islem(1'b0, REG_KONTROL, 32'h0, r, g);
        n_kontrol++;
        if (r !== {16'd868, 16'h0}) begin n_hata++; $display("FAIL reset_kontrol: got %08h required %08h", r, {16'd868, 16'h0}); end
    endtask

    task automatic test_tx_frame();
        logic [31:0] r;
        int g;
        int bulundu;
        logic [7:0] b;
        logic bek;
        b = 8'hA5;
        mon_per = 4;
        bus_islem(1'b1, REG_KONTROL, 32'h0004_0001, r, g);
        bus_islem(1'b1, REG_YAZ, {24'h0, b}, r, g);
        bulundu = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (uart_tx === 1'b0) begin bulundu = 1; break; end
        end
        n_kontrol++;
        if (bulundu == 0) begin
            n_hata++;
            $display("FAIL tx_start_timeout: got line high required start bit");
        end else begin
            for (int k = 0; k < 40; k++) begin
                if (k < 4) bek = 1'b0;
                else if (k >= 36) bek = 1'b1;
                else bek = b[(k / 4) - 1];
                n_kontrol++;
                if (uart_tx !== bek) begin
                    n_hata++;
                    $display("FAIL tx_waveform cycle %0d: got %b required %b", k, uart_tx, bek);
                end
                if (k < 39) begin @(posedge clk); #1; end
            end
        end
        for (int i = 0; i < 50 && tx_alinan.size() == 0; i++) bekle(1);
        n_kontrol++;
        if (tx_alinan.size() != 1 || tx_alinan[0] !== b) begin
            n_hata++;
            $display("FAIL tx_decoded: got %0d frames first=%02h required 1 frame A5", tx_alinan.size(),
                     tx_alinan.size() > 0 ? tx_alinan[0] : 8'h00);
        end
        tx_alinan.delete();
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (r !== durum_bekle(0, 0)) begin n_hata++; $display("FAIL tx_durum_after: got %08h required %08h", r, durum_bekle(0, 0)); end
    endtask

    task automatic test_rx();
        logic [31:0] r;
        int g;
        logic [7:0] b;
        bus_islem(1'b1, REG_KONTROL, 32'h0008_0003, r, g);
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            rx_gonder(b, 1'b1, 8);
            rx_model.push_back(b);
        end
        bekle(4);
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (r !== durum_bekle(rx_model.size(), 0)) begin n_hata++; $display("FAIL rx_durum: got %08h required %08h", r, durum_bekle(rx_model.size(), 0)); end
        while (rx_model.size() > 0) begin
            b = rx_model.pop_front();
            bus_islem(1'b0, REG_OKU, 32'h0, r, g);
            n_kontrol++;
            if (r !== {24'h0, b}) begin n_hata++; $display("FAIL rx_oku: got %08h required %08h", r, {24'h0, b}); end
        end
        bus_islem(1'b0, REG_OKU, 32'h0, r, g);
        n_kontrol++;
        if (r !== 32'h0) begin n_hata++; $display("FAIL rx_oku_empty: got %08h required 0", r); end
        bus_islem(1'b1, REG_DURUM, 32'hFFFF_FFFF, r, g);
        n_kontrol++;
        if (r !== 32'h0) begin n_hata++; $display("FAIL store_durum_rdata: got %08h required 0", r); end
        bus_islem(1'b0, REG_YAZ, 32'h0, r, g);
        n_kontrol++;
        if (r !== 32'h0) begin n_hata++; $display("FAIL load_yaz_rdata: got %08h required 0", r); end
    endtask

    task automatic test_tx_fifo_full();
        logic [31:0] r;
        int g;
        logic [7:0] b;
        mon_per = 4;
        bus_islem(1'b1, REG_KONTROL, 32'h0004_0000, r, g);
        for (int i = 0; i < DER + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_islem(1'b1, REG_YAZ, {24'h0, b}, r, g);
            if (tx_model.size() < DER) tx_model.push_back(b);
        end
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (r !== durum_bekle(0, tx_model.size())) begin n_hata++; $display("FAIL tx_full_durum: got %08h required %08h", r, durum_bekle(0, tx_model.size())); end
        bus_islem(1'b1, REG_KONTROL, 32'h0004_0001, r, g);
        for (int i = 0; i < 3000 && tx_alinan.size() < DER; i++) bekle(1);
        bekle(100);
        n_kontrol++;
        if (tx_alinan.size() != tx_model.size()) begin
            n_hata++;
            $display("FAIL tx_frame_count: got %0d required %0d", tx_alinan.size(), tx_model.size());
        end
        for (int i = 0; i < tx_model.size() && i < tx_alinan.size(); i++) begin
            n_kontrol++;
            if (tx_alinan[i] !== tx_model[i]) begin
                n_hata++;
                $display("FAIL tx_order[%0d]: got %02h required %02h", i, tx_alinan[i], tx_model[i]);
            end
        end
        tx_alinan.delete();
        tx_model.delete();
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (r !== durum_bekle(0, 0)) begin n_hata++; $display("FAIL tx_drained_durum: got %08h required %08h", r, durum_bekle(0, 0)); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] r;
        int g;
        logic [7:0] b;
        bus_islem(1'b1, REG_KONTROL, 32'h0008_0002, r, g);
        rx_gonder(8'($urandom_range(0, 255)), 1'b0, 8);
        bekle(8);
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (r !== durum_bekle(0, 0)) begin n_hata++; $display("FAIL rx_framing_durum: got %08h required %08h", r, durum_bekle(0, 0)); end
        uart_rx = 1'b0;
        bekle(2);
        uart_rx = 1'b1;
        bekle(120);
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (r !== durum_bekle(0, 0)) begin n_hata++; $display("FAIL rx_glitch_durum: got %08h required %08h", r, durum_bekle(0, 0)); end
        b = 8'($urandom_range(0, 255));
        rx_gonder(b, 1'b1, 8);
        bekle(4);
        bus_islem(1'b0, REG_OKU, 32'h0, r, g);
        n_kontrol++;
        if (r !== {24'h0, b}) begin n_hata++; $display("FAIL rx_after_errors: got %08h required %08h", r, {24'h0, b}); end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        int g;
        logic [7:0] b0, b1;
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        rx_gonder(b0, 1'b1, 8);
        rx_gonder(b1, 1'b1, 8);
        bekle(4);
        @(posedge clk); #1;
        bus_if.giris_cikis_aktif_i = 1'b1;
        bus_if.bellege_yaz_i       = 1'b0;
        bus_if.bellek_adresi_i     = adr(REG_OKU);
        #1;
        n_kontrol++;
        if (bus_if.durdur_o !== 1'b1) begin n_hata++; $display("FAIL stall_cycle1: got %b required 1", bus_if.durdur_o); end
        @(posedge clk); #1;
        n_kontrol++;
        if (bus_if.veri_gecerli_o !== 1'b1 || bus_if.durdur_o !== 1'b0) begin
            n_hata++;
            $display("FAIL stall_response: got valid=%b stall=%b required valid=1 stall=0", bus_if.veri_gecerli_o, bus_if.durdur_o);
        end
        n_kontrol++;
        if (bus_if.okunan_veri_o !== {24'h0, b0}) begin n_hata++; $display("FAIL stall_rdata: got %08h required %08h", bus_if.okunan_veri_o, {24'h0, b0}); end
        @(posedge clk); #1;
        n_kontrol++;
        if (bus_if.veri_gecerli_o !== 1'b0) begin n_hata++; $display("FAIL stall_single_pulse: got %b required 0", bus_if.veri_gecerli_o); end
        bus_if.giris_cikis_aktif_i = 1'b0;
        $display("bus LD held across response reg=2 rdata=%02h", b0);
        bus_islem(1'b0, REG_OKU, 32'h0, r, g);
        n_kontrol++;
        if (r !== {24'h0, b1}) begin n_hata++; $display("FAIL stall_single_pop: got %08h required %08h", r, {24'h0, b1}); end
        bus_islem(1'b0, REG_OKU, 32'h0, r, g);
        n_kontrol++;
        if (r !== 32'h0) begin n_hata++; $display("FAIL stall_rx_empty: got %08h required 0", r); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] r;
        int g;
        int yuksek_degil;
        mon_en = 1'b0;
        bus_islem(1'b1, REG_KONTROL, 32'h0008_0001, r, g);
        bus_islem(1'b1, REG_YAZ, 32'h0000_0000, r, g);
        bus_islem(1'b1, REG_YAZ, 32'h0000_0055, r, g);
        bekle(20);
        n_kontrol++;
        if (uart_tx !== 1'b0) begin n_hata++; $display("FAIL mid_frame_line: got %b required 0", uart_tx); end
        rst_n = 1'b0;
        bus_if.giris_cikis_aktif_i = 1'b1;
        bus_if.bellege_yaz_i       = 1'b0;
        bus_if.bellek_adresi_i     = adr(REG_DURUM);
        @(posedge clk); #1;
        n_kontrol++;
        if (uart_tx !== 1'b1) begin n_hata++; $display("FAIL reset_line_high: got %b required 1", uart_tx); end
        for (int i = 0; i < 3; i++) begin
            n_kontrol++;
            if (bus_if.veri_gecerli_o !== 1'b0) begin n_hata++; $display("FAIL reset_drops_request: got %b required 0", bus_if.veri_gecerli_o); end
            @(posedge clk); #1;
        end
        bus_if.giris_cikis_aktif_i = 1'b0;
        rst_n = 1'b1;
        $display("reset pulse applied mid-frame");
        bus_islem(1'b0, REG_DURUM, 32'h0, r, g);
        n_kontrol++;
        if (r !== durum_bekle(0, 0)) begin n_hata++; $display("FAIL reset_fifo_cleared: got %08h required %08h", r, durum_bekle(0, 0)); end
        bus_islem(1'b0, REG_KONTROL, 32'h0, r, g);
        n_kontrol++;
        if (r !== {16'd868, 16'h0}) begin n_hata++; $display("FAIL reset_ctrl_default: got %08h required %08h", r, {16'd868, 16'h0}); end
        yuksek_degil = 0;
        for (int i = 0; i < 100; i++) begin
            if (uart_tx !== 1'b1) yuksek_degil++;
            bekle(1);
        end
        n_kontrol++;
        if (yuksek_degil != 0) begin n_hata++; $display("FAIL reset_line_idle: got %0d low cycles required 0", yuksek_degil); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_rx();
        test_tx_fifo_full();
        test_rx_errors();
        test_stall();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
        $finish;
    end
endmodule
